// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULTU = 3'd0,
    OP_MULT  = 3'd1,
    OP_DIVU  = 3'd2,
    OP_DIV   = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // One radix-2 iteration per operand bit.
  function automatic int unsigned iter_count(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// Single iteration of the shared datapath: shift-and-add multiply or restoring divide.
module mult_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  // Multiply: acc = {partial product, remaining multiplier bits}, consumed LSB-first.
  assign sum       = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
  // Divide: acc = {remainder, remaining dividend bits}, consumed MSB-first.
  assign rem_shift = acc_i[2*WIDTH-1:WIDTH-1];
  assign diff      = rem_shift - {1'b0, opnd_i};

  always_comb begin
    acc_o = {sum, acc_i[WIDTH-1:1]};
    if (is_div_i) begin
      if (!diff[WIDTH]) begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_shift[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned ITERS = iter_count(WIDTH);
  localparam int unsigned CNT_W = $clog2(ITERS);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;

  logic               signed_op, start_div, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [ACC_W-1:0]   acc_step, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign signed_op = (OP == OP_MULT) || (OP == OP_DIV);
  assign start_div = (OP == OP_DIVU) || (OP == OP_DIV);
  assign sign_a    = signed_op & A[WIDTH-1];
  assign sign_b    = signed_op & B[WIDTH-1];
  assign mag_a     = sign_a ? -A : A;
  assign mag_b     = sign_b ? -B : B;

  // Sign correction applied once, in FIX, to the magnitude result.
  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign q_fix     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign r_fix     = rem_neg_q ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (acc_step)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          case (OP)
            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
              // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
              acc_d     = {{WIDTH{1'b0}}, (start_div ? mag_a : mag_b)};
              opnd_d    = start_div ? mag_b : mag_a;
              a_d       = A;
              is_div_d  = start_div;
              neg_d     = sign_a ^ sign_b;
              rem_neg_d = sign_a;
              div0_d    = (B == '0);
              cnt_d     = '0;
              busy_d    = 1'b1;
              state_d   = ST_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[ACC_W-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit that sits downstream of the ALU operand path and shares its operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles and also handles MTHI and MTLO. Results land in the architectural HI/LO registers, which MFHI/MFLO read. The control unit stalls the single-cycle pipeline while BUSY is high.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
CLK  input  1  clock, rising-edge active.
RST  input  1  asynchronous, active-high reset.
START  input  1  request; sampled only when state is IDLE.
OP  input  3  operation: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6-7 reserved (ignored).
A  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
B  input  WIDTH  rt operand (multiplier / divisor).
BUSY  output  1  high while a MULT/DIV is in flight.
DONE  output  1  one-cycle pulse when HI/LO have been updated by MULT/DIV.
HI  output  WIDTH  HI register (product upper half / remainder).
LO  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (asynchronous, RST=1): state=IDLE, HI=0, LO=0, BUSY=0, DONE=0, counter=0, and internal accumulators cleared. Asserting reset mid-operation aborts the operation. No partial result is ever written.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, START=1, OP in {0..3} at edge k:
  - Latch the magnitudes of A and B. For signed ops, magnitude = two's-complement negate if the MSB is set.
  - Latch the result signs.
  - counter=0; go to RUN. BUSY=1 from edge k.
- RUN, edges k+1..k+WIDTH: one iteration per edge.
  - Multiply: shift-and-add, radix-2, LSB-first, into a 2*WIDTH accumulator.
  - Divide: restoring, MSB-first. Shift remainder left, subtract divisor, keep the result if non-negative and set the quotient bit.
  - counter increments each edge. After the edge where counter reaches WIDTH-1, go to FIX.
- FIX, edge k+WIDTH+1:
  - Apply sign correction and write HI/LO.
  - BUSY=0, DONE=1 for exactly one cycle, state=IDLE.
  - Total: BUSY high for WIDTH+1 cycles; the result is visible in the cycle after edge k+WIDTH+1 (k+33 for WIDTH=32).
- Sign rules:
  - Product is negated (2*WIDTH wide) if sign(A) xor sign(B).
  - Quotient is negated if sign(A) xor sign(B).
  - Remainder takes the sign of A.
- Divide by zero, signed or unsigned: LO=all-ones, HI=A (original operand, unmodified). No trap.
- Signed overflow (-2^(WIDTH-1) / -1): LO=0x80000000, HI=0. This falls out naturally from magnitude arithmetic.
- MTHI / MTLO in IDLE with START=1: HI (or LO) = A at that same edge. BUSY stays 0, DONE stays 0, state stays IDLE.
- START during RUN/FIX: ignored entirely. Operands are not resampled, and the in-flight result is unaffected.
- Reserved OP with START=1: no state change.
- A/B may change freely after the START edge; only the latched copies are used.
- DONE and START in the same cycle: START is accepted (state is IDLE) and the new operation begins.

Decomposition:
- Shared package holds:
  - OP encodings (OP_MULTU..OP_MTLO).
  - State encodings (ST_IDLE, ST_RUN, ST_FIX).
  - Iteration-count constant derived from WIDTH.
- One natural sub-module: mult_div_step, a combinational single-iteration datapath. It takes accumulator, operand and mode, and returns the next accumulator for multiply-add or restore-subtract.
- Control FSM, counter, sign fix and HI/LO registers stay in mult_div_unit.

Test Plan:
1. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles DONE pulse; HI=0xFFFFFFFE, LO=0x00000001; BUSY high for exactly 33 cycles.
2. MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). Then DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=0x00000064. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MULTU 6*7 started, then START with OP=MULTU A=1 B=1 asserted at cycle 5 -> ignored; final LO=42, HI=0; single DONE pulse.
5. DIVU 1000/7 started, RST pulsed asynchronously mid-cycle at iteration 10 -> HI=0, LO=0, BUSY=0 immediately. A following DIVU 1000/7 yields LO=142, HI=6.
6. MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated the next cycle each; BUSY and DONE never assert.
